// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
// Holds FSM state encodings and the LFSR seed/feedback definition.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ARMED = 3'd2,
        S_DONE  = 3'd3,
        S_FOUL  = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; low bits exposed as a random value.
// Maximal-length polynomial, so the register never reaches all-zero.
module lfsr16
    import reaction_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [OUT_W-1:0] o_rand
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_rand = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game: random delay, stimulus LED, millisecond timing,
// with foul detection for early presses and a timeout ceiling.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        led_stimulus,
    output logic [23:0] reaction_ms,
    output logic        update,
    output logic        foul,
    output logic        timeout,
    output logic [2:0]  state
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);
    localparam logic [23:0]   MIN_D     = 24'(MIN_DELAY_MS);
    localparam logic [23:0]   TMO       = 24'(TIMEOUT_MS);

    state_t r_state;
    state_t w_next;

    logic          r_start_q;
    logic          r_react_q;
    logic [PW-1:0] r_presc;
    logic [23:0]   r_delay;
    logic [23:0]   r_ms;
    logic [23:0]   r_reaction;
    logic          r_update;
    logic          r_foul;
    logic          r_timeout;

    logic                 w_start_rise;
    logic                 w_react_rise;
    logic                 w_tick;
    logic [RAND_BITS-1:0] w_rand;
    logic [23:0]          w_rand_ext;
    logic                 w_led;
    logic                 w_load;
    logic                 w_arm;
    logic                 w_hit;
    logic                 w_tmo;
    logic                 w_early;

    lfsr16 #(
        .OUT_W (RAND_BITS)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .o_rand  (w_rand)
    );

    assign w_rand_ext   = {{(24-RAND_BITS){1'b0}}, w_rand};
    assign w_start_rise = start_btn & ~r_start_q;
    assign w_react_rise = react_btn & ~r_react_q;
    assign w_tick       = (r_presc == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q <= 1'b0;
            r_react_q <= 1'b0;
        end else begin
            r_start_q <= start_btn;
            r_react_q <= react_btn;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A press always beats delay expiry and timeout in the same cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_FOUL: begin
                if (w_start_rise) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_react_rise)       w_next = S_FOUL;
                else if (r_delay == '0) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (w_react_rise || r_ms == TMO) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_led   = 1'b0;
        w_load  = 1'b0;
        w_arm   = 1'b0;
        w_hit   = 1'b0;
        w_tmo   = 1'b0;
        w_early = 1'b0;
        unique case (1'b1)
            (r_state == S_WAIT): begin
                w_early = w_react_rise;
                w_arm   = !w_react_rise && (r_delay == '0);
            end
            (r_state == S_ARMED): begin
                w_led = 1'b1;
                w_hit = w_react_rise;
                w_tmo = !w_react_rise && (r_ms == TMO);
            end
            (r_state == S_IDLE || r_state == S_DONE || r_state == S_FOUL): begin
                w_load = w_start_rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc    <= '0;
            r_delay    <= '0;
            r_ms       <= '0;
            r_reaction <= '0;
            r_update   <= 1'b0;
            r_foul     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_load || w_arm || w_tick) r_presc <= '0;
            else                           r_presc <= r_presc + PW'(1);

            if (w_load) begin
                r_delay <= MIN_D + w_rand_ext;
            end else if (r_state == S_WAIT && w_tick && r_delay != '0) begin
                r_delay <= r_delay - 24'd1;
            end

            if (w_arm) begin
                r_ms <= '0;
            end else if (w_led && w_tick && r_ms < TMO) begin
                r_ms <= r_ms + 24'd1;
            end

            if (w_hit)      r_reaction <= r_ms;
            else if (w_tmo) r_reaction <= TMO;

            r_update <= w_hit;

            if (w_load)       r_foul <= 1'b0;
            else if (w_early) r_foul <= 1'b1;

            if (w_load)     r_timeout <= 1'b0;
            else if (w_tmo) r_timeout <= 1'b1;
        end
    end

    assign led_stimulus = w_led;
    assign reaction_ms  = r_reaction;
    assign update       = r_update;
    assign foul         = r_foul;
    assign timeout      = r_timeout;
    assign state        = r_state;

endmodule

// File: tb/tb_reaction_controller.sv
// Bench for reaction_controller: vector table, directed corner cases and
// randomized rounds predicted from cycle arithmetic of the game rules.
module tb_reaction_controller;

    localparam int T   = 4;
    localparam int MIN = 3;
    localparam int RB  = 2;
    localparam int TO  = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        led_stimulus;
    logic [23:0] reaction_ms;
    logic        update;
    logic        foul;
    logic        timeout;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_edges;
    int last_rx  = 0;

    typedef struct {
        logic       s;
        logic       r;
        logic [2:0] st;
        logic       led;
        logic       upd;
        logic       fl;
        logic       tmo;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    reaction_controller #(
        .TICKS_PER_MS (T),
        .MIN_DELAY_MS (MIN),
        .RAND_BITS    (RB),
        .TIMEOUT_MS   (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .led_stimulus (led_stimulus),
        .reaction_ms  (reaction_ms),
        .update       (update),
        .foul         (foul),
        .timeout      (timeout),
        .state        (state)
    );

    // Clock edges seen since reset release: the LFSR has stepped this often
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n_edges <= 0;
        else          n_edges <= n_edges + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start_btn = 1'b0;
        react_btn = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        last_rx = 0;
    endtask

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    // kind 0: press `off` cycles after arming (off<0: never press)
    // kind 1: early press sampled `off` edges after start (clipped to arm edge)
    task automatic round(input int kind, input int off);
        logic [15:0] lv;
        int d, a, p, e_end, cmax, upd_seen;
        bit hit;
        react_btn = 1'b0;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        chk("rnd_wait_state", state, 1);
        lv  = lfsr_at(n_edges - 1);
        d   = MIN + int'(lv[1:0]);
        a   = 4 * d + 1;
        hit = 1'b0;
        if (kind == 1) begin
            p     = (off > a) ? a : off;
            e_end = p;
        end else if (off >= 0 && off <= TO * T) begin
            p     = a + off + 1;
            e_end = p;
            hit   = 1'b1;
        end else begin
            p     = (off < 0) ? -1 : a + off + 1;
            e_end = a + TO * T + 1;
        end
        cmax     = (p > e_end + 1) ? p : e_end + 1;
        upd_seen = 0;
        for (int c = 1; c <= cmax; c++) begin
            if (c == p) react_btn = 1'b1;
            tick();
            if (update && c != e_end) upd_seen++;
            if (kind == 0 && c == a - 1) begin
                chk("pre_arm_led", led_stimulus, 0);
                chk("pre_arm_state", state, 1);
            end
            if (kind == 0 && c == a) begin
                chk("arm_led", led_stimulus, 1);
                chk("arm_state", state, 2);
            end
            if (c == e_end) begin
                if (kind == 1) begin
                    chk("foul_state", state, 4);
                    chk("foul_flag", foul, 1);
                    chk("foul_led", led_stimulus, 0);
                    chk("foul_update", update, 0);
                    chk("foul_rx_kept", reaction_ms, last_rx);
                end else if (hit) begin
                    last_rx = off / T;
                    chk("hit_state", state, 3);
                    chk("hit_update", update, 1);
                    chk("hit_rx", reaction_ms, last_rx);
                    chk("hit_timeout", timeout, 0);
                end else begin
                    last_rx = TO;
                    chk("tmo_state", state, 3);
                    chk("tmo_update", update, 0);
                    chk("tmo_flag", timeout, 1);
                    chk("tmo_rx", reaction_ms, TO);
                end
            end
            if (c == e_end + 1) chk("update_one_cycle", update, 0);
        end
        chk("stray_update", upd_seen, 0);
        react_btn = 1'b0;
        tick();
    endtask

    initial begin
        int waited, entries, upds, fouls, prev;

        vt[0] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};

        do_reset();
        chk("rst_state", state, 0);
        chk("rst_led", led_stimulus, 0);
        chk("rst_rx", reaction_ms, 0);
        chk("rst_update", update, 0);
        chk("rst_foul", foul, 0);
        chk("rst_timeout", timeout, 0);

        for (int i = 0; i < 10; i++) begin
            start_btn = vt[i].s;
            react_btn = vt[i].r;
            tick();
            chk($sformatf("vec%0d_state", i), state, vt[i].st);
            chk($sformatf("vec%0d_led", i), led_stimulus, vt[i].led);
            chk($sformatf("vec%0d_update", i), update, vt[i].upd);
            chk($sformatf("vec%0d_foul", i), foul, vt[i].fl);
            chk($sformatf("vec%0d_timeout", i), timeout, vt[i].tmo);
            chk($sformatf("vec%0d_rx", i), reaction_ms, 0);
        end
        start_btn = 1'b0;
        react_btn = 1'b0;
        tick();

        round(0, 28);
        round(1, 2);
        round(0, -1);
        round(0, 80);
        round(0, 79);

        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        waited = 0;
        while (!led_stimulus && waited < 100) begin
            tick();
            waited++;
        end
        chk("armed_reached", led_stimulus, 1);
        repeat (10) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_led", led_stimulus, 0);
        chk("async_rst_rx", reaction_ms, 0);
        chk("async_rst_update", update, 0);
        chk("async_rst_foul", foul, 0);
        chk("async_rst_timeout", timeout, 0);
        tick();
        reset_n = 1'b1;
        last_rx = 0;
        tick();
        chk("post_rst_state", state, 0);
        chk("post_rst_update", update, 0);
        round(0, 12);

        start_btn = 1'b1;
        react_btn = 1'b1;
        entries = 0;
        upds    = 0;
        fouls   = 0;
        prev    = int'(state);
        for (int c = 0; c < 250; c++) begin
            tick();
            if (prev != 1 && state == 3'd1) entries++;
            if (update) upds++;
            if (foul) fouls++;
            prev = int'(state);
        end
        chk("held_rounds", entries, 1);
        chk("held_updates", upds, 0);
        chk("held_fouls", fouls, 0);
        chk("held_end_state", state, 3);
        chk("held_timeout", timeout, 1);
        start_btn = 1'b0;
        react_btn = 1'b0;
        tick();
        last_rx = int'(reaction_ms);
        chk("held_rx", last_rx, TO);

        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 7)) tick();
            if ($urandom_range(0, 3) == 0) begin
                round(1, int'($urandom_range(1, 30)));
            end else if ($urandom_range(0, 9) == 0) begin
                round(0, -1);
            end else begin
                round(0, int'($urandom_range(0, 90)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
